rcc_checker: RTL and testbench
==============================

Name: rcc_checker

Overview:
- Self-checking monitor for the 4-bit ripple carry counter. It is the observing end of the counter's reset/count interface.
- It samples the counter output every clk rising edge and confirms that:
  - the counter holds 0 while the counter reset is asserted;
  - the counter advances by exactly +1 (mod 2^WIDTH) per clock cycle otherwise.
- It reports mismatch pulses, a sticky fail flag and statistics. It sits next to the counter in benches and in on-board self-test, and is synthesizable.

Parameters:
- WIDTH, 4, counter width in bits.
- STAT_W, 8, width of the error and wrap statistic counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  checker reset.
- cnt_rst  input  1  copy of the reset driven into the observed counter.
- q_in  input  WIDTH  observed counter output, sampled at clk rising edge.
- locked  output  1  checker is tracking a valid count sequence.
- err  output  1  one-cycle pulse on each detected mismatch.
- err_sticky  output  1  set on first mismatch; cleared only by reset.
- err_count  output  STAT_W  number of mismatches, saturating.
- wrap_count  output  STAT_W  number of checked all-ones-to-0 transitions, saturating.
- expected  output  WIDTH  value predicted for the next sample.

Behaviour:
- Reset: one clock, synchronous, active-high reset. Reset values:
  - state = IDLE;
  - locked = 0, err = 0, err_sticky = 0;
  - err_count = 0, wrap_count = 0, expected = 0.
  - Reset overrides every other event, including mid-TRACK.
- IDLE:
  - no checking;
  - cnt_rst = 1 -> RST_GRACE.
- RST_GRACE (first sample of a counter reset):
  - q_in is not checked; this absorbs the counter's reset latency;
  - cnt_rst = 1 -> RST_HOLD;
  - cnt_rst = 0 -> ANCHOR (single-cycle reset pulse).
- RST_HOLD:
  - each sample with q_in != 0 is a mismatch;
  - cnt_rst = 0 -> ANCHOR.
- ANCHOR (first sample after cnt_rst deasserts):
  - q_in must be 0 or 1; any other value is a mismatch;
  - expected <= q_in + 1;
  - -> TRACK.
- TRACK:
  - q_in != expected is a mismatch;
  - in every case expected <= q_in + 1 (resynchronise), so one glitch yields exactly one error, not a cascade;
  - locked = 1 only in TRACK, and only when the previous sample matched.
- Counter re-reset: cnt_rst = 1 in ANCHOR or TRACK -> RST_GRACE, locked <= 0. This event is not an error.
- Mismatch handling (registered, visible the cycle after the offending sample):
  - err = 1 for one cycle;
  - err_sticky <= 1;
  - err_count += 1, saturating at 2^STAT_W - 1.
- Wrap counting: in TRACK, a matched sample equal to 0 whose previous sample was all-ones increments wrap_count (saturating).
- Arithmetic: all q arithmetic is modulo 2^WIDTH, so all-ones + 1 = 0.
- Latency: err, err_count, wrap_count, locked and expected are all registered one cycle after the sample.
- X/Z on q_in: not handled in RTL; the bench asserts on it separately.

Decomposition:
- Shared package rcc_pkg holds:
  - state encoding: IDLE, RST_GRACE, RST_HOLD, ANCHOR, TRACK (3-bit);
  - localparam COUNT_W = 4, reused by the counter and this checker.
- One sub-module is natural: sat_counter (parameter W; inputs clk, reset, inc; output value, saturating).
  - It is instantiated twice, for err_count and wrap_count.
- The FSM and compare logic stay in rcc_checker.

Test Plan:
1. Counter reset for 2 cycles, then a clean count for 40 cycles -> err never pulses, err_count = 0, wrap_count = 2, locked = 1 from the 2nd TRACK sample.
2. Force q_in = 5 where 4 is expected, then resume 6, 7, ... -> exactly one err pulse, err_count = 1, err_sticky = 1, no further errors.
3. Hold q_in = 3 during RST_HOLD for 3 samples -> err_count = 3; q_in = 9 at ANCHOR -> err_count = 4.
4. Assert cnt_rst mid-count (q = 11) for 1 cycle, then count from 0 -> no err, locked drops, then re-locks, expected = 1 after the anchor of 0.
5. Inject 300 mismatches with STAT_W = 8 -> err_count saturates at 255, err_sticky stays 1; checker reset -> all outputs 0, state IDLE.
6. Apply checker reset in the same cycle as a mismatch -> err = 0, err_count = 0, err_sticky = 0 next cycle.

Source files
------------

// File: rtl/rcc_pkg.sv
// Shared definitions for the ripple carry counter and its checker.
package rcc_pkg;

  // Width of the observed ripple carry counter.
  localparam int COUNT_W = 4;

  // Checker FSM states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST_GRACE = 3'd1,
    RST_HOLD  = 3'd2,
    ANCHOR    = 3'd3,
    TRACK     = 3'd4
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter
  import rcc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] value_reg;

  // Count up on inc, holding at the maximum value instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_reg <= '0;
    end else if (inc && (value_reg != MAX_VAL)) begin
      value_reg <= value_reg + W'(1);
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/rcc_checker.sv
// Monitor for the ripple carry counter: checks that the counter sits at 0
// while held in reset and then advances by exactly one per clock.
module rcc_checker
  import rcc_pkg::*;
#(
  parameter int WIDTH  = COUNT_W,
  parameter int STAT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cnt_rst,
  input  logic [WIDTH-1:0]  q_in,
  output logic              locked,
  output logic              err,
  output logic              err_sticky,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  expected
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] expected_reg, expected_next;
  logic [WIDTH-1:0] q_prev_reg;
  logic             locked_reg, locked_next;
  logic             err_reg, err_next;
  logic             sticky_reg;
  logic             wrap_next;
  logic [WIDTH-1:0] q_plus1;
  logic             match;

  // Modulo arithmetic: all-ones + 1 wraps to 0 naturally.
  assign q_plus1 = q_in + WIDTH'(1);
  assign match   = (q_in == expected_reg);

  // State, prediction and flag registers; checker reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      expected_reg <= '0;
      q_prev_reg   <= '0;
      locked_reg   <= 1'b0;
      err_reg      <= 1'b0;
      sticky_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      expected_reg <= expected_next;
      q_prev_reg   <= q_in;
      locked_reg   <= locked_next;
      err_reg      <= err_next;
      sticky_reg   <= sticky_reg | err_next;
    end
  end

  // Next-state, mismatch detection and prediction update.
  always_comb begin
    state_next    = state_reg;
    expected_next = expected_reg;
    locked_next   = 1'b0;
    err_next      = 1'b0;
    wrap_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cnt_rst) state_next = RST_GRACE;
      end
      RST_GRACE: begin
        // First reset sample absorbs the counter's reset latency: no check.
        state_next = cnt_rst ? RST_HOLD : ANCHOR;
      end
      RST_HOLD: begin
        err_next = (q_in != '0);
        if (!cnt_rst) state_next = ANCHOR;
      end
      ANCHOR: begin
        if (cnt_rst) begin
          state_next = RST_GRACE;
        end else begin
          // The counter may already have taken its first step out of reset.
          err_next      = (q_in > WIDTH'(1));
          expected_next = q_plus1;
          state_next    = TRACK;
        end
      end
      TRACK: begin
        if (cnt_rst) begin
          state_next = RST_GRACE;
        end else begin
          err_next      = !match;
          locked_next   = match;
          wrap_next     = match && (q_in == '0) && (q_prev_reg == ALL_ONES);
          // Always resynchronise to the observed value so a single glitch
          // produces a single error rather than a cascade.
          expected_next = q_plus1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Mismatch statistic.
  sat_counter #(.W(STAT_W)) u_err_count (
    .clk   (clk),
    .reset (reset),
    .inc   (err_next),
    .value (err_count)
  );

  // Checked all-ones-to-zero transitions.
  sat_counter #(.W(STAT_W)) u_wrap_count (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_next),
    .value (wrap_count)
  );

  assign locked     = locked_reg;
  assign err        = err_reg;
  assign err_sticky = sticky_reg;
  assign expected   = expected_reg;

endmodule

// File: tb/tb_rcc_checker.sv
// Table-driven bench for rcc_checker: each record holds the inputs for one
// clock and the outputs required one cycle later.
module tb_rcc_checker;

  logic       clk;
  logic       reset;
  logic       cnt_rst;
  logic [3:0] q_in;
  logic       locked;
  logic       err;
  logic       err_sticky;
  logic [7:0] err_count;
  logic [7:0] wrap_count;
  logic [3:0] expected;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic       cr;
    logic [3:0] q;
    logic       e_err;
    logic       e_sticky;
    logic       e_locked;
    logic [3:0] e_exp;
    logic [7:0] e_errc;
    logic [7:0] e_wrapc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  rcc_checker #(.WIDTH(4), .STAT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_rst    (cnt_rst),
    .q_in       (q_in),
    .locked     (locked),
    .err        (err),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .wrap_count (wrap_count),
    .expected   (expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input int rst, input int cr, input int q,
                              input int e_err, input int e_sticky, input int e_locked,
                              input int e_exp, input int e_errc, input int e_wrapc);
    vec_t v;
    v.rst      = rst[0];
    v.cr       = cr[0];
    v.q        = q[3:0];
    v.e_err    = e_err[0];
    v.e_sticky = e_sticky[0];
    v.e_locked = e_locked[0];
    v.e_exp    = e_exp[3:0];
    v.e_errc   = e_errc[7:0];
    v.e_wrapc  = e_wrapc[7:0];
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0d want=%0d", name, idx, act, want);
    end
  endtask

  initial begin
    int wr;
    int ec;
    logic [3:0] q;
    vec_t e;

    reset   = 1'b1;
    cnt_rst = 1'b0;
    q_in    = 4'd0;

    // Checker reset.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Test 1: two-cycle counter reset then a clean count.
    add(0, 1, 7, 0, 0, 0, 0, 0, 0);   // IDLE: unchecked
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);   // RST_GRACE
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);   // RST_HOLD, q=0 ok
    add(0, 0, 1, 0, 0, 0, 2, 0, 0);   // ANCHOR with 1
    wr = 0;
    for (int i = 0; i < 40; i++) begin
      q = 4'((2 + i) % 16);
      if (q == 4'd0) wr++;
      add(0, 0, q, 0, 0, 1, (q + 1) % 16, 0, wr);
    end

    // Test 2: keep counting to 3, then 5 where 4 is expected, then resume.
    for (int i = 0; i < 10; i++) begin
      q = 4'((10 + i) % 16);
      if (q == 4'd0) wr++;
      add(0, 0, q, 0, 0, 1, (q + 1) % 16, 0, wr);
    end
    add(0, 0, 5, 1, 1, 0, 6, 1, 3);
    add(0, 0, 6, 0, 1, 1, 7, 1, 3);
    add(0, 0, 7, 0, 1, 1, 8, 1, 3);
    add(0, 0, 8, 0, 1, 1, 9, 1, 3);

    // Test 3: nonzero during reset hold, then a bad anchor.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 6, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 3, 1, 1, 0, 0, 1, 0);
    add(0, 1, 3, 1, 1, 0, 0, 2, 0);
    add(0, 0, 3, 1, 1, 0, 0, 3, 0);
    add(0, 0, 9, 1, 1, 0, 10, 4, 0);
    add(0, 0, 10, 0, 1, 1, 11, 4, 0);

    // Test 4: one-cycle counter re-reset mid-count, restart from 0.
    add(0, 1, 11, 0, 1, 0, 11, 4, 0);
    add(0, 0, 0, 0, 1, 0, 11, 4, 0);
    add(0, 0, 0, 0, 1, 0, 1, 4, 0);
    add(0, 0, 1, 0, 1, 1, 2, 4, 0);
    add(0, 0, 2, 0, 1, 1, 3, 4, 0);

    // Test 5: 300 consecutive mismatches saturate the error count.
    q  = 4'd2;
    ec = 4;
    for (int i = 0; i < 300; i++) begin
      q = q + 4'd2;
      if (ec < 255) ec++;
      add(0, 0, q, 1, 1, 0, (q + 1) % 16, ec, 0);
    end
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 5, 0, 0, 0, 0, 0, 0);   // IDLE: not checked

    // Test 6: checker reset coincident with a mismatch.
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2, 0, 0);
    add(0, 0, 2, 0, 0, 1, 3, 0, 0);
    add(1, 0, 7, 0, 0, 0, 0, 0, 0);
    add(0, 0, 8, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset   = vecs[i].rst;
      cnt_rst = vecs[i].cr;
      q_in    = vecs[i].q;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      $display("vec %0d rst=%0b cr=%0b q=%0d -> err=%0b stk=%0b lck=%0b exp=%0d ec=%0d wc=%0d",
               i, e.rst, e.cr, e.q, err, err_sticky, locked, expected, err_count, wrap_count);
      chk("err",        i, 32'(err),        32'(e.e_err));
      chk("err_sticky", i, 32'(err_sticky), 32'(e.e_sticky));
      chk("locked",     i, 32'(locked),     32'(e.e_locked));
      chk("expected",   i, 32'(expected),   32'(e.e_exp));
      chk("err_count",  i, 32'(err_count),  32'(e.e_errc));
      chk("wrap_count", i, 32'(wrap_count), 32'(e.e_wrapc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
